// File: rtl/nrisc_pc_stack_if.sv
// PC / return-stack bus between the NRISC control block (master) and the PC stack (slave).
// Carries the per-strobe action request and the registered PC and stack status.
interface nrisc_pc_stack_if #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned STACK_DEPTH = 8
);
  localparam int unsigned LvlW = $clog2(STACK_DEPTH + 1);

  logic              PC_en;
  logic [1:0]        PC_ctrl;
  logic              PC_call;
  logic [ADDR_W-1:0] PC_jump_addr;
  logic [ADDR_W-1:0] PC_addr;
  logic [ADDR_W-1:0] PC_stack_top;
  logic [LvlW-1:0]   PC_stack_level;
  logic              PC_stack_full;
  logic              PC_stack_empty;
  logic              PC_stack_err;

  modport master (
    output PC_en, PC_ctrl, PC_call, PC_jump_addr,
    input  PC_addr, PC_stack_top, PC_stack_level, PC_stack_full, PC_stack_empty, PC_stack_err
  );

  modport slave (
    input  PC_en, PC_ctrl, PC_call, PC_jump_addr,
    output PC_addr, PC_stack_top, PC_stack_level, PC_stack_full, PC_stack_empty, PC_stack_err
  );
endinterface

// File: rtl/nrisc_pc_stack.sv
// Program counter with a LIFO return-address stack: increment, hold, jump/call and return,
// one action per PC_en strobe. Overflow/underflow set a sticky error cleared only by reset.
module nrisc_pc_stack #(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input logic              clk,
  input logic              rst,
  nrisc_pc_stack_if.slave  bus
);
  localparam int unsigned LvlW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [PtrW-1:0]   push_idx;
  logic [PtrW-1:0]   top_idx;
  logic              full;
  logic              empty;
  logic              push;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign push_idx = PtrW'(level_q);
  assign top_idx  = PtrW'(level_q - LvlW'(1));
  assign full     = (level_q == LvlW'(STACK_DEPTH));
  assign empty    = (level_q == '0);

  always_comb begin
    pc_d    = pc_q;
    level_d = level_q;
    err_d   = err_q;
    push    = 1'b0;
    if (bus.PC_en) begin
      case (bus.PC_ctrl)
        2'd0: pc_d = pc_inc;
        2'd2: begin
          pc_d = bus.PC_jump_addr;
          if (bus.PC_call) begin
            // A call on a full stack still jumps; only the push is dropped.
            if (full) begin
              err_d = 1'b1;
            end else begin
              push    = 1'b1;
              level_d = level_q + LvlW'(1);
            end
          end
        end
        2'd3: begin
          // Return on an empty stack falls through to the next instruction.
          if (empty) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d    = stack_q[top_idx];
            level_d = level_q - LvlW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_VECTOR;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset; level alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign bus.PC_addr        = pc_q;
  assign bus.PC_stack_top   = empty ? '0 : stack_q[top_idx];
  assign bus.PC_stack_level = level_q;
  assign bus.PC_stack_full  = full;
  assign bus.PC_stack_empty = empty;
  assign bus.PC_stack_err   = err_q;
endmodule

// File: tb/tb_nrisc_pc_stack.sv
// Bench for nrisc_pc_stack: directed scenarios then random strobes, checked against a
// queue-based model of the PC and return stack.
module tb_nrisc_pc_stack;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  nrisc_pc_stack_if #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) bus ();

  nrisc_pc_stack #(
    .ADDR_W      (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stk[$];
  bit            m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [AW-1:0] exp_top;
    exp_top = (m_stk.size() == 0) ? '0 : m_stk[m_stk.size()-1];
    check_eq({tag, ".pc"},    32'(bus.PC_addr), 32'(m_pc));
    check_eq({tag, ".level"}, 32'(bus.PC_stack_level), 32'(m_stk.size()));
    check_eq({tag, ".top"},   32'(bus.PC_stack_top), 32'(exp_top));
    check_eq({tag, ".full"},  32'(bus.PC_stack_full), 32'(m_stk.size() == DEPTH));
    check_eq({tag, ".empty"}, 32'(bus.PC_stack_empty), 32'(m_stk.size() == 0));
    check_eq({tag, ".err"},   32'(bus.PC_stack_err), 32'(m_err));
  endtask

  task automatic model_step(input bit en, input logic [1:0] ctrl, input bit call,
                            input logic [AW-1:0] addr);
    logic [AW-1:0] nxt;
    nxt = m_pc + 16'd1;
    if (!en) return;
    case (ctrl)
      2'd0: m_pc = nxt;
      2'd2: begin
        if (call) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
          else m_err = 1'b1;
        end
        m_pc = addr;
      end
      2'd3: begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc  = nxt;
          m_err = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic strobe(input string tag, input bit en, input logic [1:0] ctrl, input bit call,
                        input logic [AW-1:0] addr);
    @(negedge clk);
    bus.PC_en        = en;
    bus.PC_ctrl      = ctrl;
    bus.PC_call      = call;
    bus.PC_jump_addr = addr;
    @(posedge clk);
    model_step(en, ctrl, call, addr);
    #1;
    check_state(tag);
  endtask

  // Reset with an arbitrary strobe presented at the same edge; the strobe must be discarded.
  task automatic do_reset(input string tag, input logic [1:0] ctrl);
    @(negedge clk);
    rst              = 1'b0;
    bus.PC_en        = 1'b1;
    bus.PC_ctrl      = ctrl;
    bus.PC_call      = 1'b1;
    bus.PC_jump_addr = 16'hBEEF;
    @(posedge clk);
    m_pc  = '0;
    m_err = 1'b0;
    m_stk.delete();
    #1;
    check_state(tag);
    @(negedge clk);
    rst       = 1'b1;
    bus.PC_en = 1'b0;
  endtask

  logic [AW-1:0] calls[DEPTH];

  initial begin
    bus.PC_en        = 1'b0;
    bus.PC_ctrl      = 2'd0;
    bus.PC_call      = 1'b0;
    bus.PC_jump_addr = '0;
    m_pc  = '0;
    m_err = 1'b0;

    do_reset("reset", 2'd0);
    check_eq("reset.pc_const", 32'(bus.PC_addr), 32'h0);

    for (int i = 0; i < 3; i++) strobe("inc", 1'b1, 2'd0, 1'b0, '0);
    check_eq("inc3.pc_const", 32'(bus.PC_addr), 32'h3);
    strobe("dis", 1'b0, 2'd0, 1'b0, '0);
    strobe("dis", 1'b0, 2'd2, 1'b1, 16'h1234);
    check_eq("dis.pc_const", 32'(bus.PC_addr), 32'h3);

    strobe("jmp_ffff", 1'b1, 2'd2, 1'b0, 16'hFFFF);
    strobe("wrap", 1'b1, 2'd0, 1'b0, '0);
    check_eq("wrap.pc_const", 32'(bus.PC_addr), 32'h0);
    strobe("hold", 1'b1, 2'd1, 1'b1, 16'h5555);
    strobe("hold", 1'b1, 2'd1, 1'b0, '0);

    strobe("jmp10", 1'b1, 2'd2, 1'b0, 16'h0010);
    strobe("call200", 1'b1, 2'd2, 1'b1, 16'h0200);
    check_eq("call200.top_const", 32'(bus.PC_stack_top), 32'h0011);
    for (int i = 0; i < 5; i++) strobe("inc", 1'b1, 2'd0, 1'b0, '0);
    strobe("call300", 1'b1, 2'd2, 1'b1, 16'h0300);
    check_eq("call300.top_const", 32'(bus.PC_stack_top), 32'h0206);
    check_eq("call300.level_const", 32'(bus.PC_stack_level), 32'd2);
    strobe("ret1", 1'b1, 2'd3, 1'b0, '0);
    check_eq("ret1.pc_const", 32'(bus.PC_addr), 32'h0206);
    strobe("ret2", 1'b1, 2'd3, 1'b0, '0);
    check_eq("ret2.pc_const", 32'(bus.PC_addr), 32'h0011);

    for (int i = 0; i < DEPTH; i++) begin
      calls[i] = AW'($urandom);
      strobe("fill", 1'b1, 2'd2, 1'b1, calls[i]);
    end
    check_eq("fill.full_const", 32'(bus.PC_stack_full), 32'd1);
    strobe("ovf", 1'b1, 2'd2, 1'b1, 16'h0400);
    check_eq("ovf.pc_const", 32'(bus.PC_addr), 32'h0400);
    check_eq("ovf.err_const", 32'(bus.PC_stack_err), 32'd1);
    for (int i = 0; i < DEPTH; i++) strobe("drain", 1'b1, 2'd3, 1'b0, '0);
    check_eq("drain.empty_const", 32'(bus.PC_stack_empty), 32'd1);

    do_reset("reset2", 2'd2);
    strobe("jmp5", 1'b1, 2'd2, 1'b0, 16'h0005);
    strobe("unf", 1'b1, 2'd3, 1'b0, '0);
    check_eq("unf.pc_const", 32'(bus.PC_addr), 32'h0006);
    check_eq("unf.err_const", 32'(bus.PC_stack_err), 32'd1);
    strobe("sticky_call", 1'b1, 2'd2, 1'b1, 16'h0100);
    strobe("sticky_ret", 1'b1, 2'd3, 1'b0, '0);

    for (int i = 0; i < 3; i++) strobe("pre_rst", 1'b1, 2'd2, 1'b1, AW'($urandom));
    do_reset("rst_ret", 2'd3);
    check_eq("rst_ret.level_const", 32'(bus.PC_stack_level), 32'd0);

    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset("rnd_rst", 2'($urandom));
      end else begin
        // Bias towards calls/returns so the stack regularly hits both limits.
        logic [1:0] c;
        int unsigned k;
        k = $urandom_range(0, 9);
        c = (k < 2) ? 2'd0 : (k < 3) ? 2'd1 : (k < 6) ? 2'd2 : 2'd3;
        strobe("rnd", ($urandom_range(0, 9) != 0), c, 1'($urandom_range(0, 3) != 0),
               AW'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nrisc_pc_stack.md
# nrisc_pc_stack

Program counter and hardware return-address stack for the NRISC core; sits directly upstream of the CPU control block. Holds the current instruction address and presents it to instruction memory. Each update strobe applies one of four actions selected by the CPU's 2-bit PC control: increment, hold, jump (optionally a call), or return. It supplies the JMP/CALL/RET datapath that the control block's states 2 and 3 drive.

## Interface
- ADDR_W, 16, width of instruction address and stack entries
- STACK_DEPTH, 8, number of return-address entries (power of two, ≥2)
- RESET_VECTOR, 16'h0000, PC value after reset
- clk  in  1  main clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset, sampled on rising clk)
- PC_en  in  1  update strobe (the CPU's PC clock pulse); action applied only when high
- PC_ctrl  in  2  0=increment, 1=hold, 2=jump/call, 3=return
- PC_call  in  1  with PC_ctrl=2: push PC+1 before jumping; ignored otherwise
- PC_jump_addr  in  ADDR_W  jump target (ULA output)
- PC_addr  out  ADDR_W  current PC, registered, to instruction memory
- PC_stack_top  out  ADDR_W  entry at top of stack; 0 when empty
- PC_stack_level  out  $clog2(STACK_DEPTH+1)  number of valid entries
- PC_stack_full  out  1  level == STACK_DEPTH
- PC_stack_empty  out  1  level == 0
- PC_stack_err  out  1  sticky overflow/underflow flag

## Operation
- Reset (rst=0 at edge): PC_addr=RESET_VECTOR, level=0, err=0, top=0, empty=1, full=0. Stack array contents are don't-care. Reset overrides PC_en.
- PC_en=0: all state held regardless of PC_ctrl/PC_call.
- ctrl=0: PC ← PC+1, modulo 2^ADDR_W (2^ADDR_W−1 wraps to 0).
- ctrl=1: PC unchanged; stack unchanged. Used during LW/SW memory phase.
- ctrl=2, PC_call=0: PC ← PC_jump_addr; stack unchanged.
- ctrl=2, PC_call=1, not full: stack[level] ← PC+1 (wrapping); level+1; PC ← PC_jump_addr.
- ctrl=2, PC_call=1, full: push suppressed, existing entries preserved; jump still taken; err ← 1.
- ctrl=3, not empty: PC ← stack[level−1]; level−1.
- ctrl=3, empty: PC ← PC+1 (fall through); level stays 0; err ← 1.
- err is cleared only by reset.
- Status outputs full/empty/top/level are combinational from registered level and array; they reflect state after the last edge.
- Stack is LIFO. No wrap-around of the stack pointer; level saturates at 0 and STACK_DEPTH.

## Timing
- Single-cycle: an action sampled with PC_en=1 at edge N is visible on PC_addr, level, top, full/empty and err immediately after edge N.
- Back-to-back strobes on consecutive cycles are legal; each uses the state left by the previous edge.
- A return directly after a call returns to call-site PC+1 with no bubble.
- Inputs must be stable at the rising edge. PC_jump_addr is sampled only when ctrl=2 and PC_en=1.
- Reset mid-operation (any state, any ctrl) takes effect at that edge. The strobe sampled at that edge is discarded.
- No internal state machine beyond the PC register and stack pointer; throughput is one action per cycle.

## Test plan
- Reset then 3 strobes with ctrl=0 → PC_addr 0x0000→0x0001→0x0002→0x0003; empty=1, err=0. PC_en=0 for 2 cycles with ctrl=0 → PC stays 0x0003.
- Set PC=0xFFFF via jump, one increment → PC_addr=0x0000. ctrl=1 strobes → PC unchanged.
- PC=0x0010, call to 0x0200 → PC=0x0200, top=0x0011, level=1. Nested call from 0x0205 to 0x0300 → top=0x0206, level=2. Two returns → PC=0x0206, then 0x0011, empty=1, err=0.
- 8 calls (DEPTH=8) → full=1, err=0. 9th call to 0x0400 → PC=0x0400, level=8, top unchanged, err=1. 8 returns pop the original 8 addresses in reverse order.
- After reset, return on empty at PC=0x0005 → PC=0x0006, level=0, err=1. err stays 1 through later valid calls/returns until rst=0.
- 3 calls pushed, then rst=0 asserted concurrently with a ctrl=3 strobe → PC=RESET_VECTOR, level=0, empty=1, err=0, no pop effect.
